// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access stage: bus widths, the packed
// layouts of the EXE->MEM and MEM->WB buses, load-type codes and the
// data-SRAM response FSM state encoding.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 74;
   localparam int MS_TO_WS_BUS_WD = 70;

   localparam logic [2:0] LOAD_LW  = 3'd0;
   localparam logic [2:0] LOAD_LB  = 3'd1;
   localparam logic [2:0] LOAD_LBU = 3'd2;
   localparam logic [2:0] LOAD_LH  = 3'd3;
   localparam logic [2:0] LOAD_LHU = 3'd4;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,   // no outstanding load response
      MS_WAIT = 2'd1,   // load in stage, SRAM data not yet returned
      MS_HOLD = 2'd2    // data returned while WB stalled; held in rdata_buf
   } ms_state_e;

   typedef struct packed {
      logic [2:0]  load_type;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Valid/allowin pipeline handshake carrying a WD-bit bus between two stages.
//   valid   : producer has an instruction on bus
//   allowin : consumer can take it this cycle
//   bus     : instruction payload
// master = producing stage, slave = consuming stage.
// ---------------------------------------------------------------------------
interface mem_stage_if #(parameter int WD = 74);
   logic          valid;
   logic          allowin;
   logic [WD-1:0] bus;

   modport master (output valid, output bus, input  allowin);
   modport slave  (input  valid, input  bus, output allowin);
endinterface

// File: rtl/mem_stage_load_align.sv
// ---------------------------------------------------------------------------
// mem_stage_load_align
// Combinational sub-word load extraction.
//   load_type : LW/LB/LBU/LH/LHU code (unknown codes behave as LW)
//   off       : byte offset, alu_result[1:0]
//   rd        : raw 32-bit read word
//   word      : extracted, sign/zero extended result
// Halfword loads look only at off[1]; misalignment is handled elsewhere.
// ---------------------------------------------------------------------------
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  load_type,
   input  logic [1:0]  off,
   input  logic [31:0] rd,
   output logic [31:0] word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (off)
         2'd0:    byte_sel = rd[7:0];
         2'd1:    byte_sel = rd[15:8];
         2'd2:    byte_sel = rd[23:16];
         default: byte_sel = rd[31:24];
      endcase
      half_sel = off[1] ? rd[31:16] : rd[15:0];

      case (load_type)
         LOAD_LB:  word = {{24{byte_sel[7]}}, byte_sel};
         LOAD_LBU: word = {24'd0, byte_sel};
         LOAD_LH:  word = {{16{half_sel[15]}}, half_sel};
         LOAD_LHU: word = {16'd0, half_sel};
         default:  word = rd;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 5-stage MIPS pipeline (between EXE and WB).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   es_ms (slave)      : EXE->MEM handshake; es_ms.allowin is ms_allowin
//   ms_ws (master)     : MEM->WB handshake; ms_ws.allowin is ws_allowin
//   data_sram_data_ok  : read data valid this cycle
//   data_sram_rdata    : read data
//   ms_forward         : final_result, forwarded to EXE
//   ms_dest            : dest when a register-writing instruction is valid, else 0
//   ms_load_pending    : valid load whose data has not yet arrived
// A load's SRAM response may arrive after a variable delay; if it arrives
// while WB is stalled it is captured in rdata_buf so the SRAM side is free
// to move on (rdata may change after data_ok).
// ---------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   mem_stage_if.slave  es_ms,
   mem_stage_if.master ms_ws,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic [31:0] ms_forward,
   output logic [4:0]  ms_dest,
   output logic        ms_load_pending
);

   logic        ms_valid;
   es_to_ms_t   bus_r;
   ms_state_e   state, state_nxt;
   logic        rdata_buf_valid;
   logic [31:0] rdata_buf;
   logic        buf_capture, buf_release;

   logic        ms_ready_go;
   logic        ms_allowin;
   logic        is_load;
   logic [31:0] rd;
   logic [31:0] load_word;
   logic [31:0] final_result;
   ms_to_ws_t   out_bus;

   // ---------------- handshake ----------------
   assign is_load     = ms_valid && bus_r.res_from_mem;
   assign ms_ready_go = !bus_r.res_from_mem || data_sram_data_ok || rdata_buf_valid;
   assign ms_allowin  = !ms_valid || (ms_ready_go && ms_ws.allowin);

   assign es_ms.allowin = ms_allowin;
   assign ms_ws.valid   = ms_valid && ms_ready_go;

   // ---------------- load data path ----------------
   // The held copy wins: once captured, the live SRAM bus may carry other data.
   assign rd = rdata_buf_valid ? rdata_buf : data_sram_rdata;

   mem_stage_load_align u_load_align (
      .load_type (bus_r.load_type),
      .off       (bus_r.alu_result[1:0]),
      .rd        (rd),
      .word      (load_word)
   );

   assign final_result = bus_r.res_from_mem ? load_word : bus_r.alu_result;

   assign out_bus.gr_we        = bus_r.gr_we;
   assign out_bus.dest         = bus_r.dest;
   assign out_bus.final_result = final_result;
   assign out_bus.pc           = bus_r.pc;
   assign ms_ws.bus            = out_bus;

   assign ms_forward      = final_result;
   assign ms_dest         = (ms_valid && bus_r.gr_we) ? bus_r.dest : 5'd0;
   assign ms_load_pending = is_load && !ms_ready_go;

   // ---------------- response FSM ----------------
   // Only advances for a valid load. data_ok seen in IDLE without one is
   // a stray response and is ignored.
   always_comb begin
      state_nxt   = state;
      buf_capture = 1'b0;
      buf_release = 1'b0;
      case (state)
         MS_IDLE: begin
            if (is_load) begin
               if (!data_sram_data_ok) begin
                  state_nxt = MS_WAIT;
               end else if (!ms_ws.allowin) begin
                  state_nxt   = MS_HOLD;
                  buf_capture = 1'b1;
               end
            end
         end
         MS_WAIT: begin
            if (data_sram_data_ok) begin
               if (ms_ws.allowin) begin
                  state_nxt = MS_IDLE;
               end else begin
                  state_nxt   = MS_HOLD;
                  buf_capture = 1'b1;
               end
            end
         end
         MS_HOLD: begin
            if (ms_ws.allowin) begin
               state_nxt   = MS_IDLE;
               buf_release = 1'b1;
            end
         end
         default: state_nxt = MS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= MS_IDLE;
         ms_valid        <= 1'b0;
         rdata_buf_valid <= 1'b0;
         rdata_buf       <= 32'd0;
         bus_r           <= '0;
      end else begin
         state <= state_nxt;
         if (ms_allowin) begin
            ms_valid <= es_ms.valid;
         end
         if (es_ms.valid && ms_allowin) begin
            bus_r <= es_ms.bus;
         end
         if (buf_capture) begin
            rdata_buf       <= data_sram_rdata;
            rdata_buf_valid <= 1'b1;
         end else if (buf_release) begin
            rdata_buf_valid <= 1'b0;
         end
      end
   end

endmodule
